// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Takes 32 CALC cycles per op, then a FIX cycle for sign correction and the HI/LO write.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        zero_q, zero_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        in_signed, in_sa, in_sb;
  logic [31:0] in_a_abs, in_b_abs;
  logic [32:0] mul_sum, rem_sh, rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, zero_hi;

  always_comb begin
    in_signed = ~op[0];
    in_sa     = in_signed & src_a[31];
    in_sb     = in_signed & src_b[31];
    in_a_abs  = in_sa ? (~src_a + 32'd1) : src_a;
    in_b_abs  = in_sb ? (~src_b + 32'd1) : src_b;

    // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    // Divide: dividend sits in acc[31:0] and is replaced by quotient bits.
    rem_sh   = {rem_q[31:0], acc_q[31]};
    rem_diff = rem_sh - {1'b0, b_q};

    prod_fix = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = sa_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    // Reconstruct the original dividend for the divide-by-zero result.
    zero_hi  = sa_q ? (~a_q + 32'd1) : a_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          op_d    = op;
          a_d     = in_a_abs;
          b_d     = in_b_abs;
          sa_d    = in_sa;
          sb_d    = in_sb;
          count_d = '0;
          rem_d   = '0;
          zero_d  = op[1] && (src_b == 32'd0);
          acc_d   = {32'd0, (op[1] ? in_a_abs : in_b_abs)};
          state_d = (op[1] && (src_b == 32'd0)) ? FIX : CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (op_q[1]) begin
            if (!rem_diff[32]) begin
              rem_d = rem_diff;
              acc_d = {32'd0, acc_q[30:0], 1'b1};
            end else begin
              rem_d = rem_sh;
              acc_d = {32'd0, acc_q[30:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (op_q[1] && zero_q) begin
            hi_d = zero_hi;
            lo_d = '1;
            dz_d = 1'b1;
          end else if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
            dz_d = 1'b0;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
            dz_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zero_q  <= zero_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_dz = 1'b0;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed/unsigned arithmetic on wide integers.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint     sa, sb, q, r;
    logic [63:0] p;
    rdz = 1'b0;
    case (o)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        rh = p[63:32];
        rl = p[31:0];
      end
      2'd1: begin
        p  = {32'd0, a} * {32'd0, b};
        rh = p[63:32];
        rl = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          rh  = a;
          rl  = 32'hFFFF_FFFF;
          rdz = 1'b1;
        end else if (o == 2'd2) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          p  = 64'(q);
          rl = p[31:0];
          p  = 64'(r);
          rh = p[31:0];
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endtask

  // Issue one op (optionally with a coincident MTHI) and check latency, busy span and result.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic mthi, input logic [31:0] mval);
    int unsigned lat = 0, busy_cnt = 0, exp_lat;
    logic got = 1'b0;
    logic [31:0] rh, rl;
    logic rdz;
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi_we = mthi; wdata = mval;
    tick();
    start = 1'b0; hi_we = 1'b0;
    if (mthi) check({tag, "_mthi"}, {32'd0, hi}, {32'd0, mval});
    for (int i = 0; i < 100 && !got; i++) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
      if (done) got = 1'b1;
    end
    exp_lat = (o[1] && b == 32'd0) ? 1 : 33;
    ref_op(o, a, b, rh, rl, rdz);
    exp_hi = rh; exp_lo = rl; exp_dz = rdz;
    if (!got) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
      check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
    end
    tick();
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int unsigned dcnt;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic        got;

    #2;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    tick();
    rst_n = 1'b1;

    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
    check("multu_max_hi_abs", {32'd0, hi}, 64'hFFFF_FFFE);
    check("multu_max_lo_abs", {32'd0, lo}, 64'h0000_0001);
    do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, '0);
    check("mult_neg_lo_abs", {32'd0, lo}, 64'hFFFF_FFF1);
    do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, '0);
    check("div_neg_lo_abs", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_neg_hi_abs", {32'd0, hi}, 64'hFFFF_FFFF);
    do_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0, '0);
    check("divu_zero_hi_abs", {32'd0, hi}, 64'h64);
    do_op("divu_9_3", 2'd3, 32'd9, 32'd3, 1'b0, '0);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
    check("div_ovf_lo_abs", {32'd0, lo}, 64'h8000_0000);
    do_op("div_zero_s", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, '0);
    do_op("mult_clr_dz", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, '0);
    do_op("mthi_start", 2'd0, 32'd12, 32'hFFFF_FFFE, 1'b1, 32'h0000_ABCD);

    // start and cancel together in IDLE: nothing starts
    start = 1'b1; cancel = 1'b1; op = 2'd1; src_a = 32'd4; src_b = 32'd4;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", {63'd0, busy}, 64'd0);
    check("cancel_start_lo", {32'd0, lo}, {32'd0, exp_lo});

    // start and lo_we while busy are ignored
    start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; src_a = 32'd7; src_b = 32'd7; lo_we = 1'b1; wdata = 32'h55;
    tick();
    start = 1'b0; lo_we = 1'b0;
    check("busy_lo_we", {32'd0, lo}, {32'd0, exp_lo});
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    check("busy_start_done", {63'd0, got}, 64'd1);
    check("busy_start_lo", {32'd0, lo}, 64'd6);
    check("busy_start_hi", {32'd0, hi}, 64'd0);
    exp_hi = '0; exp_lo = 32'd6; exp_dz = 1'b0;
    tick();

    // cancel mid-divide leaves HI/LO untouched
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'h11; exp_lo = 32'h11;
    check("mt_hi", {32'd0, hi}, 64'h11);
    check("mt_lo", {32'd0, lo}, 64'h11);
    start = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("cancel_pre_busy", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      tick();
      if (done) dcnt++;
    end
    check("cancel_no_done", 64'(dcnt), 64'd0);
    check("cancel_hi", {32'd0, hi}, 64'h11);
    check("cancel_lo", {32'd0, lo}, 64'h11);
    check("cancel_dz", {63'd0, div_zero}, {63'd0, exp_dz});

    // asynchronous reset mid-multiply
    start = 1'b1; op = 2'd0; src_a = 32'd1234; src_b = 32'hFFFF_0000;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    tick();
    rst_n = 1'b1;
    do_op("post_rst", 2'd0, 32'd1234, 32'hFFFF_0000, 1'b0, '0);

    for (int k = 0; k < 24; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op("rand", ro, ra, rb, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  one-cycle request from decode stage for MULT/MULTU/DIV/DIVU.
REQ-004 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 src_a  input  32  rs operand (multiplicand/dividend), after forwarding; sampled with start.
REQ-006 src_b  input  32  rt operand (multiplier/divisor), after forwarding; sampled with start.
REQ-007 cancel  input  1  squash of the in-flight op by branch/jump flush.
REQ-008 hi_we / lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-009 wdata  input  32  MTHI/MTLO write data.
REQ-010 hi / lo  output  32 each  architectural HI/LO registers, read by MFHI/MFLO.
REQ-011 busy  output  1  op in flight; pipeline holds PC/IR while busy and an MFHI/MFLO/MULT/DIV is in decode.
REQ-012 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-013 div_zero  output  1  sticky flag: last completed divide had src_b==0.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX; busy=1 in CALC and FIX only.
REQ-015 In IDLE, start=1 SHALL latch op/src_a/src_b, load count=0, and go to CALC next edge (edge E0).
REQ-016 Signed ops SHALL latch |src_a|, |src_b| plus result-sign bits; unsigned ops SHALL latch the raw operands.
REQ-017 Multiply SHALL be iterative shift-add, one multiplier bit per CALC cycle, 64-bit accumulator.
REQ-018 Divide SHALL be iterative restoring division, one quotient bit per CALC cycle, 33-bit partial remainder.
REQ-019 CALC SHALL last exactly 32 cycles (count 0..31), then go to FIX.
REQ-020 FIX SHALL apply sign correction and write hi/lo, assert done for that one cycle, and return to IDLE; done rises 33 cycles after E0.
REQ-021 Multiply result SHALL be placed as hi=product[63:32], lo=product[31:0]; MULT negates the 64-bit product when the source signs differ.
REQ-022 Divide result SHALL be placed as lo=quotient, hi=remainder; DIV negates the quotient when the signs differ and gives the remainder the sign of the dividend.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0; no flag.
REQ-024 A divide with src_b==0 SHALL skip CALC and go straight to FIX: hi=src_a, lo=0xFFFFFFFF, div_zero=1, done one cycle after E0.
REQ-025 div_zero SHALL clear on the next completed op with a nonzero divisor, or on any completed multiply.
REQ-026 start while busy SHALL be ignored; latched operands SHALL be unchanged.
REQ-027 cancel in CALC or FIX SHALL return to IDLE next edge with no done pulse and hi/lo/div_zero unchanged; cancel in IDLE has no effect.
REQ-028 cancel and start in the same IDLE cycle: cancel SHALL win and no op starts.
REQ-029 hi_we/lo_we SHALL update hi/lo only in IDLE and SHALL be ignored while busy.
REQ-030 hi_we/lo_we coincident with start in IDLE SHALL perform the write; the op still starts.
REQ-031 The FIX write of hi/lo SHALL take precedence over any concurrent hi_we/lo_we.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, count=0, asynchronously and at any point mid-operation.
REQ-033 After rst_n rises, the first start SHALL be accepted on the first clock edge.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at E0+33; hi=0xFFFFFFFE, lo=0x00000001; busy=1 for exactly 33 cycles.
REQ-035 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIVU 100 / 0 -> done at E0+1; hi=0x00000064, lo=0xFFFFFFFF, div_zero=1; a following DIVU 9/3 -> lo=3, hi=0, div_zero=0.
REQ-037 Start MULTU 2x3, then at cycle 5 assert start with 7x7 and lo_we with 0x55 -> second start and lo_we ignored; result lo=6.
REQ-038 Start DIVU 50/7 (hi=lo=0x11 beforehand), cancel at cycle 10 -> IDLE at cycle 11, no done, hi=lo=0x11.
REQ-039 Drive rst_n low at cycle 20 of a MULT -> busy=0, hi=lo=0 immediately; no done; a new op after reset completes correctly.
